// File: rtl/exter_io_pattern_gen.sv
// Board bring-up pattern generator for the external IO headers: four test patterns
// advanced by a prescaler tick, with a debounced push-button that cycles the mode.
module exter_io_pattern_gen #(
    parameter int CH_NUM     = 70,
    parameter int DIV_WIDTH  = 25,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key,
    output logic [CH_NUM-1:0] io_out,
    output logic [1:0]        mode,
    output logic              tick
);

    localparam int WALK_W = $clog2(CH_NUM);
    localparam int DEB_W  = $clog2(DEB_CYCLES);

    typedef enum logic [1:0] {
        MODE_ALT   = 2'd0,
        MODE_WALK  = 2'd1,
        MODE_COUNT = 2'd2,
        MODE_ALL   = 2'd3
    } mode_e;

    logic [DIV_WIDTH-1:0] cnt, cnt_n;
    logic                 phase, phase_n;
    logic [WALK_W-1:0]    walk_idx, walk_n;
    logic [CH_NUM-1:0]    count, count_n;
    mode_e                mode_q, mode_n;
    logic [CH_NUM-1:0]    io_n;

    logic             key_meta, key_sync;
    logic             deb_key, deb_key_d;
    logic [DEB_W-1:0] deb_cnt;
    logic             press;

    assign tick  = &cnt;
    assign mode  = mode_q;
    assign press = deb_key_d & ~deb_key;

    // Key path: the raw button is idle-high, so every stage resets to 1 to avoid
    // a spurious press event coming out of reset.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta  <= 1'b1;
            key_sync  <= 1'b1;
            deb_key   <= 1'b1;
            deb_key_d <= 1'b1;
            deb_cnt   <= '0;
        end else begin
            key_meta  <= key;
            key_sync  <= key_meta;
            deb_key_d <= deb_key;
            if (key_sync == deb_key) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                deb_key <= key_sync;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the block can leave one unassigned and infer a latch.
    always_comb begin
        cnt_n   = cnt + DIV_WIDTH'(1);
        phase_n = phase;
        walk_n  = walk_idx;
        count_n = count;
        mode_n  = mode_q;
        if (press) begin
            // A mode change restarts the pattern and swallows a coincident tick.
            mode_n  = mode_e'(mode_q + 2'd1);
            cnt_n   = '0;
            phase_n = 1'b0;
            walk_n  = '0;
            count_n = '0;
        end else if (tick) begin
            phase_n = ~phase;
            walk_n  = (walk_idx == WALK_W'(CH_NUM - 1)) ? '0 : walk_idx + WALK_W'(1);
            count_n = count + CH_NUM'(1);
        end

        io_n = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            unique case (mode_n)
                MODE_ALT:   io_n[i] = phase_n ^ (i % 2 == 1);
                MODE_WALK:  io_n[i] = (WALK_W'(i) == walk_n);
                MODE_COUNT: io_n[i] = count_n[i];
                MODE_ALL:   io_n[i] = phase_n;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            phase    <= 1'b0;
            walk_idx <= '0;
            count    <= '0;
            mode_q   <= MODE_ALT;
            for (int i = 0; i < CH_NUM; i++) io_out[i] <= (i % 2 == 1);
        end else begin
            cnt      <= cnt_n;
            phase    <= phase_n;
            walk_idx <= walk_n;
            count    <= count_n;
            mode_q   <= mode_n;
            io_out   <= io_n;
        end
    end

endmodule

// File: doc/exter_io_pattern_gen.md
# exter_io_pattern_gen

Parametrised board-bring-up pattern generator for the external IO headers. It drives CH_NUM output pins with one of four selectable test patterns, advanced by a programmable prescaler tick. A debounced push-button steps through the modes, so header pins can be checked for toggling, shorts, stuck bits and pin ordering with a scope or LEDs. It sits in the top-level test design alongside the UART loopback and WS2812 blocks, and drives the exter_io buses.

## Interface
- CH_NUM, 70, number of driven IO channels; minimum 2.
- DIV_WIDTH, 25, prescaler width; tick period is 2^DIV_WIDTH clk cycles.
- DEB_CYCLES, 1_000_000, number of clk cycles the synchronised key must differ from its debounced value before the debounced value changes; minimum 2.

Ports:
- clk  input  1  system clock; all logic is in this single domain.
- rst  input  1  asynchronous, active-high reset.
- key  input  1  raw push-button, active-low (pressed = 0), asynchronous to clk.
- io_out  output  CH_NUM  registered pattern output.
- mode  output  2  current mode: 0 ALT, 1 WALK, 2 COUNT, 3 ALL.
- tick  output  1  one-cycle pulse each time the prescaler wraps.

## Operation
- **Prescaler:** DIV_WIDTH-bit counter `cnt`, increments every cycle and wraps. `tick` = 1 in the cycle where cnt == all-ones.
- **Pattern state** advances on tick:
  - `phase` (1 bit) toggles.
  - `walk_idx` ($clog2(CH_NUM) bits) increments; CH_NUM-1 wraps to 0 (non-power-of-2 safe).
  - `count` (CH_NUM bits) increments, wrapping modulo 2^CH_NUM.
- **Output per mode** (bit i of io_out):
  - ALT: i[0] ^ phase. Even pins = phase, odd pins = ~phase.
  - WALK: (i == walk_idx).
  - COUNT: count[i].
  - ALL: phase.
- **Key path:**
  - 2-flop synchroniser, reset to 1.
  - Debounce counter clears whenever the synchronised value equals `deb_key`.
  - Otherwise it counts. When it reaches DEB_CYCLES-1, `deb_key` takes the synchronised value and the counter clears. `deb_key` resets to 1.
  - Press event = `deb_key` transitions 1→0. A release never changes the mode.
- **Mode change:**
  - A press event sets mode ← mode+1 mod 4 (3 wraps to 0).
  - In the same edge, cnt, phase, walk_idx and count all clear to 0.
- **Simultaneous press event and tick:** the mode change wins, and that tick's state advance is discarded. `tick` still pulses, since it is a combinational decode of cnt.

## Timing
- Reset values:
  - cnt = 0, phase = 0, walk_idx = 0, count = 0, mode = 0, tick = 0.
  - Synchroniser and deb_key = 1.
  - io_out = ALT pattern with phase 0: bit i = i[0], i.e. …1010.
- io_out and mode are registered from next-state values. They update on the same edge that ends the tick cycle (or the press-event cycle). There is no additional pipeline delay.
- Key latency: a key falling edge held stable reaches deb_key after 2 sync cycles + DEB_CYCLES cycles (±1 for async sampling). mode/io_out update on the following edge.
- A key pulse shorter than DEB_CYCLES synchronised cycles produces no event.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). The first tick after release occurs 2^DIV_WIDTH cycles later.

## Test plan
Bench parameters: CH_NUM=8, DIV_WIDTH=3, DEB_CYCLES=4.

1. **Reset:** hold rst, then release → io_out=8'hAA, mode=0, tick=0. First tick pulses exactly 8 cycles after release.
2. **ALT:** free-run → io_out sequence AA→55→AA on successive ticks, changing on the edge after each tick cycle. tick is high 1 cycle in every 8.
3. **Press and WALK:** key low for 12 cycles → mode=1 within 2+4+1 cycles (±1) and io_out=8'h01 with cnt=0. Successive ticks give 02,04,…,80, then wrap to 01.
4. **Glitch rejection:** key low for 2 cycles, then high → mode stays 0, io_out pattern undisturbed. Key released after a valid press → no mode change.
5. **COUNT, ALL and mode wrap:**
   - Mode 2 → io_out 00,01,02,03 on ticks.
   - Mode 3 → 00,FF,00.
   - A press in mode 3 → mode 0, io_out=AA.
   - A press event aligned with cnt==7 → no state advance, all state cleared.
6. **Reset mid-run:** in mode 2 with count=5, pulse rst for 1 cycle → io_out=AA and mode=0 immediately; the next tick comes 8 cycles after release.
